key_io_device: RTL and testbench

Memory-mapped input device for the four push-buttons. It sits directly upstream of the memory unit's I/O read mux and serves load/store accesses at ADDR_KEY and a control register. It synchronizes and debounces raw KEY inputs and presents pressed keys as 1. It captures every debounced change in a ready flag, and records a missed change in an overrun flag.

---
 rtl/io_pkg.sv | 41 ++++
 rtl/key_debouncer.sv | 78 +++++++
 rtl/key_io_device.sv | 173 +++++++++++++++++
 tb/tb_key_io_device.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
//   Shared definitions for the memory-mapped key input device: register
//   addresses, KCTRL bit positions, the debounce defaults and a small status
//   struct with a helper that places it on the read bus.
// ----------------------------------------------------------------------------
package io_pkg;

  // Register map (full 32-bit compare).
  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;  // key data, read-only
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;  // key control/status

  // KCTRL bit positions.
  localparam int KCTRL_READY   = 0;
  localparam int KCTRL_OVERRUN = 1;
  localparam int KCTRL_IE      = 8;

  // Debounce defaults: 10 ms at 50 MHz; the counter must hold the value - 1.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_BITS        = 20;

  localparam int NUM_KEYS = 4;

  // Software-visible status held in KCTRL.
  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } kctrl_t;

  // Places the status fields at their KCTRL bit positions; all other bits 0.
  function automatic logic [31:0] kctrl_word(input kctrl_t s);
    logic [31:0] w;
    w                = '0;
    w[KCTRL_READY]   = s.ready;
    w[KCTRL_OVERRUN] = s.overrun;
    w[KCTRL_IE]      = s.ie;
    return w;
  endfunction

endpackage : io_pkg

// File: rtl/key_debouncer.sv
// ----------------------------------------------------------------------------
// key_debouncer
//   One key: two-flop synchronizer followed by a stability counter. A new
//   level is accepted only after the synchronized input has disagreed with
//   the accepted state for DEBOUNCE_CYCLES consecutive cycles; any shorter
//   disagreement clears the counter and is discarded.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   key_n_i   raw key, active-low (0 = pressed), asynchronous to clk
//   stable_o  debounced key state, active-high (1 = pressed)
//   toggle_o  1 in the cycle whose clock edge flips stable_o
// ----------------------------------------------------------------------------
module key_debouncer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = DEFAULT_CNT_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic stable_o,
  output logic toggle_o
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q;
  logic                sync2_q;
  logic                stable_q;
  logic                stable_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;
  logic                differ;

  // The raw key is active-low and stable is active-high, so the two agree
  // when their levels are opposite; equal levels mean a pending change.
  assign differ = (sync2_q == stable_q);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    toggle_o = 1'b0;
    if (!differ) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      toggle_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // Synchronizer flops reset to 1 (released) so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule : key_debouncer

// File: rtl/key_io_device.sv
// ----------------------------------------------------------------------------
// key_io_device
//   Memory-mapped input device for the four push-buttons. Each key is
//   synchronized and debounced; KDATA presents the debounced keys (pressed
//   = 1). Any accepted change sets the ready flag; a change that arrives
//   while ready is still set and not being read sets the overrun flag.
//
//   Optional feature (macro KEY_INTR_EN): KCTRL bit 8 becomes a read/write
//   interrupt enable and intr is a registered copy of IE & ready. Without
//   the macro, bit 8 reads 0, writes to it are ignored, and intr is 0.
//
// Ports
//   clk      system clock
//   reset    asynchronous, active-high reset
//   KEY      raw keys, active-low, asynchronous to clk
//   addr     memory address
//   isLoad   load access this cycle
//   isStore  store access this cycle (wins over isLoad)
//   wrData   store data
//   rdData   read data, zero unless a load hits KDATA or KCTRL
//   intr     interrupt request
// ----------------------------------------------------------------------------
module key_io_device
  import io_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = DEFAULT_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  KEY,
  input  logic [DBITS-1:0]     addr,
  input  logic                 isLoad,
  input  logic                 isStore,
  input  logic [DBITS-1:0]     wrData,
  output logic [DBITS-1:0]     rdData,
  output logic                 intr
);

  // --------------------------------------------------------------------------
  // Debounce
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] toggle;
  logic                change;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_BITS        (CNT_BITS)
    ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .key_n_i  (KEY[i]),
      .stable_o (stable[i]),
      .toggle_o (toggle[i])
    );
  end

  // Several keys flipping on the same edge count as a single change.
  assign change = |toggle;

  // --------------------------------------------------------------------------
  // Address decode. A simultaneous load and store is a store only, so the
  // read side effect (clearing ready) and the read data are both suppressed.
  // --------------------------------------------------------------------------
  logic hit_kdata;
  logic hit_kctrl;
  logic rd_access;
  logic kdata_rd;
  logic kctrl_rd;
  logic kctrl_wr;

  assign hit_kdata = (addr == DBITS'(ADDR_KDATA));
  assign hit_kctrl = (addr == DBITS'(ADDR_KCTRL));
  assign rd_access = isLoad & ~isStore;
  assign kdata_rd  = rd_access & hit_kdata;
  assign kctrl_rd  = rd_access & hit_kctrl;
  assign kctrl_wr  = isStore & hit_kctrl;

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  logic ready_q;
  logic ready_d;
  logic overrun_q;
  logic overrun_d;
  logic ie_q;

  always_comb begin
    ready_d   = ready_q;
    overrun_d = overrun_q;

    // A change that will be lost because ready is still pending and nobody is
    // consuming it right now is an overrun; this beats a clearing store.
    if (change && ready_q && !kdata_rd) begin
      overrun_d = 1'b1;
    end else if (kctrl_wr && !wrData[KCTRL_OVERRUN]) begin
      overrun_d = 1'b0;
    end

    // A new change re-arms ready even if KDATA is being read this cycle.
    if (change) begin
      ready_d = 1'b1;
    end else if (kdata_rd) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional interrupt
  // --------------------------------------------------------------------------
`ifdef KEY_INTR_EN
  logic ie_d;
  logic intr_q;

  assign ie_d = kctrl_wr ? wrData[KCTRL_IE] : ie_q;

  // intr follows ready one cycle later in both directions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q   <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      intr_q <= ie_q & ready_q;
    end
  end

  assign intr = intr_q;
`else
  assign ie_q = 1'b0;
  assign intr = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read data: purely combinational and zero when not selected, so it can be
  // OR-ed into the memory unit's read mux. A KDATA read shows the flags as
  // they were before this cycle's clear.
  // --------------------------------------------------------------------------
  kctrl_t      status;
  logic [31:0] status_word;

  assign status.ie      = ie_q;
  assign status.overrun = overrun_q;
  assign status.ready   = ready_q;
  assign status_word    = kctrl_word(status);

  always_comb begin
    rdData = '0;
    if (kdata_rd) begin
      rdData[NUM_KEYS-1:0] = stable;
    end else if (kctrl_rd) begin
      rdData = DBITS'(status_word);
    end
  end

  // Most store-data bits have no destination in this device.
  logic unused_wrdata;
  assign unused_wrdata = ^wrData;

endmodule : key_io_device

// File: tb/tb_key_io_device.sv
// ----------------------------------------------------------------------------
// tb_key_io_device
//   Self-checking bench for key_io_device with DEBOUNCE_CYCLES = 4. Directed
//   scenarios check exact latencies and flag priorities against constants; a
//   randomized phase checks every cycle against a reference model that
//   accepts a key level once the last DEBOUNCE_CYCLES synchronized samples
//   all disagree with the accepted state.
// ----------------------------------------------------------------------------
module tb_key_io_device;

  localparam int D = 4;
  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
`ifdef KEY_INTR_EN
  localparam bit HAS_IE = 1'b1;
`else
  localparam bit HAS_IE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  KEY;
  logic [31:0] addr;
  logic        isLoad;
  logic        isStore;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        intr;

  int n_vec;
  int n_err;

  key_io_device #(
    .DBITS           (32),
    .DEBOUNCE_CYCLES (D),
    .CNT_BITS        (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .KEY     (KEY),
    .addr    (addr),
    .isLoad  (isLoad),
    .isStore (isStore),
    .wrData  (wrData),
    .rdData  (rdData),
    .intr    (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [3:0] m_stable;
  bit         m_ready;
  bit         m_ovr;
  bit         m_ie;
  bit         m_intr;
  logic [3:0] m_hist[$];  // raw KEY seen at each edge, oldest first

  task automatic model_reset();
    m_stable = 4'h0;
    m_ready  = 1'b0;
    m_ovr    = 1'b0;
    m_ie     = 1'b0;
    m_intr   = 1'b0;
    m_hist   = {};
    for (int j = 0; j < D + 2; j++) m_hist.push_back(4'hF);
  endtask

  task automatic model_step();
    logic [3:0] flip;
    bit rd;
    bit wr;
    bit chg;
    bit pending;
    m_hist.push_back(KEY);
    while (m_hist.size() > D + 2) void'(m_hist.pop_front());
    // The newest two samples are still inside the synchronizer; the D before
    // them are what the debouncer has seen on the last D edges.
    flip = 4'h0;
    for (int b = 0; b < 4; b++) begin
      pending = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (bit'(!m_hist[j][b]) == bit'(m_stable[b])) pending = 1'b0;
      end
      flip[b] = pending;
    end
    chg = (flip != 4'h0);
    rd  = isLoad && !isStore && addr == A_KDATA;
    wr  = isStore && addr == A_KCTRL;
    m_intr = HAS_IE && m_ie && m_ready;
    if (chg && m_ready && !rd) m_ovr = 1'b1;
    else if (wr && !wrData[1]) m_ovr = 1'b0;
    if (chg) m_ready = 1'b1;
    else if (rd) m_ready = 1'b0;
    if (HAS_IE && wr) m_ie = wrData[8];
    m_stable = m_stable ^ flip;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  function automatic logic [31:0] exp_rd();
    logic [31:0] v;
    v = 32'h0;
    if (isLoad && !isStore && addr == A_KDATA) v = {28'h0, m_stable};
    else if (isLoad && !isStore && addr == A_KCTRL)
      v = {23'h0, m_ie, 6'h0, m_ovr, m_ready};
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers: drive on the falling edge, settle 1 ns, then the caller
  // samples rdData / intr well away from the rising edge.
  // --------------------------------------------------------------------------
  task automatic apply(input logic [3:0] k, input bit ld, input bit st,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    KEY     = k;
    isLoad  = ld;
    isStore = st;
    addr    = a;
    wrData  = wd;
    #1;
  endtask

  task automatic ld_kdata(input logic [3:0] k);
    apply(k, 1'b1, 1'b0, A_KDATA, 32'h0);
  endtask

  task automatic ld_kctrl(input logic [3:0] k);
    apply(k, 1'b1, 1'b0, A_KCTRL, 32'h0);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    // Start a debounce, then reset in the middle of it.
    for (int i = 0; i < 4; i++) ld_kctrl(4'h0);
    #3 reset = 1'b1;
    KEY = 4'hF;
    #1;
    n_vec++;
    if (rdData !== 32'h0 || intr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_during: rdData=%h intr=%b, want 0/0", rdData, intr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ld_kdata(4'hF);
    n_vec++;
    if (rdData !== 32'h0) begin
      n_err++;
      $display("FAIL reset_kdata: got %h want 00000000", rdData);
    end
    ld_kctrl(4'hF);
    n_vec++;
    if (rdData !== 32'h0) begin
      n_err++;
      $display("FAIL reset_kctrl: got %h want 00000000", rdData);
    end
    n_vec++;
    if (intr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_intr: got %b want 0", intr);
    end
  endtask

  task automatic test_latency();
    logic [31:0] want;
    apply(4'hE, 1'b1, 1'b0, A_KCTRL, 32'h0);  // the raw edge
    for (int n = 1; n <= 10; n++) begin
      if (n <= 5 || n == 7) ld_kdata(4'hE);
      else ld_kctrl(4'hE);
      if (n <= 5) want = 32'h0;       // KDATA, not yet accepted
      else if (n == 6) want = 32'h1;  // KCTRL, ready set on edge 6
      else if (n == 7) want = 32'h1;  // KDATA shows key 0
      else want = 32'h0;              // KCTRL, ready cleared by that read
      n_vec++;
      if (rdData !== want) begin
        n_err++;
        $display("FAIL latency n=%0d: got %h want %h", n, rdData, want);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 8; i++) ld_kctrl(4'hF);  // release key 0
    ld_kdata(4'hF);                              // consume that change
    n_vec++;
    if (rdData !== 32'h0) begin
      n_err++;
      $display("FAIL glitch_pre: got %h want 00000000", rdData);
    end
    for (int i = 0; i < 3; i++) ld_kctrl(4'hD);  // 3-cycle glitch on key 1
    for (int i = 0; i < 8; i++) begin
      if (i[0]) ld_kdata(4'hF);
      else ld_kctrl(4'hF);
      n_vec++;
      if (rdData !== 32'h0) begin
        n_err++;
        $display("FAIL glitch i=%0d: got %h want 00000000", i, rdData);
      end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) ld_kctrl(4'hE);
    for (int i = 0; i < 8; i++) ld_kctrl(4'hF);
    n_vec++;
    if (rdData !== 32'h3) begin
      n_err++;
      $display("FAIL overrun_set: got %h want 00000003", rdData);
    end
    apply(4'hF, 1'b0, 1'b1, A_KCTRL, 32'h0);
    ld_kctrl(4'hF);
    n_vec++;
    if (rdData !== 32'h1) begin
      n_err++;
      $display("FAIL overrun_clear: got %h want 00000001", rdData);
    end
    ld_kdata(4'hF);
    n_vec++;
    if (rdData !== 32'h0) begin
      n_err++;
      $display("FAIL overrun_kdata: got %h want 00000000", rdData);
    end
    ld_kctrl(4'hF);
    n_vec++;
    if (rdData !== 32'h0) begin
      n_err++;
      $display("FAIL overrun_ready_clr: got %h want 00000000", rdData);
    end
  endtask

  task automatic test_read_collision();
    for (int i = 0; i < 8; i++) ld_kctrl(4'hD);
    n_vec++;
    if (rdData !== 32'h1) begin
      n_err++;
      $display("FAIL collide_pre: got %h want 00000001", rdData);
    end
    ld_kctrl(4'hF);                       // release edge
    for (int n = 1; n <= 4; n++) ld_kctrl(4'hF);
    ld_kdata(4'hF);                       // spans the accepting edge
    n_vec++;
    if (rdData !== 32'h2) begin
      n_err++;
      $display("FAIL collide_kdata: got %h want 00000002", rdData);
    end
    ld_kctrl(4'hF);
    n_vec++;
    if (rdData !== 32'h1) begin
      n_err++;
      $display("FAIL collide_flags: got %h want 00000001", rdData);
    end
    ld_kdata(4'hF);
  endtask

  task automatic test_intr();
    logic [31:0] want;
    bit          want_i;
    apply(4'hF, 1'b0, 1'b1, A_KCTRL, 32'h100);
    ld_kctrl(4'hB);                       // press key 2
    for (int n = 1; n <= 10; n++) begin
      if (n == 8) ld_kdata(4'hB);
      else ld_kctrl(4'hB);
      if (n == 8) want = 32'h4;
      else if (n < 6 || n >= 9) want = HAS_IE ? 32'h100 : 32'h0;
      else want = HAS_IE ? 32'h101 : 32'h1;
      want_i = HAS_IE && (n == 7 || n == 8 || n == 9);
      n_vec++;
      if (rdData !== want || intr !== want_i) begin
        n_err++;
        $display("FAIL intr n=%0d: rdData=%h intr=%b want %h/%b",
                 n, rdData, intr, want, want_i);
      end
    end
    apply(4'hF, 1'b0, 1'b1, A_KCTRL, 32'h0);
  endtask

  task automatic test_reset_held();
    @(negedge clk);
    reset = 1'b1;
    KEY   = 4'h7;                         // key 3 held through reset
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      ld_kctrl(4'h7);
      n_vec++;
      if (rdData !== (n == 6 ? 32'h1 : 32'h0)) begin
        n_err++;
        $display("FAIL reset_held n=%0d: got %h want %h",
                 n, rdData, (n == 6 ? 32'h1 : 32'h0));
      end
    end
    ld_kdata(4'h7);
    n_vec++;
    if (rdData !== 32'h8) begin
      n_err++;
      $display("FAIL reset_held_kdata: got %h want 00000008", rdData);
    end
  endtask

  task automatic test_random();
    logic [3:0]  k;
    int          hold;
    int          op;
    logic [31:0] a;
    logic [31:0] wd;
    bit          ld;
    bit          st;
    logic [31:0] want;
    k    = 4'hF;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        k    = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 2 * D + 3);
      end
      hold--;
      op = $urandom_range(0, 7);
      wd = $urandom;
      ld = 1'b0;
      st = 1'b0;
      a  = $urandom;
      case (op)
        0:       begin ld = 1'b1; end
        1, 2:    begin ld = 1'b1; a = A_KDATA; end
        3, 4:    begin ld = 1'b1; a = A_KCTRL; end
        5:       begin st = 1'b1; a = A_KCTRL; end
        6:       begin st = 1'b1; a = A_KDATA; end
        default: begin ld = 1'b1; st = 1'b1; a = A_KDATA; end
      endcase
      apply(k, ld, st, a, wd);
      want = exp_rd();
      n_vec++;
      if (rdData !== want || intr !== m_intr) begin
        n_err++;
        $display("FAIL random c=%0d: rdData=%h intr=%b want %h/%b",
                 c, rdData, intr, want, m_intr);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    KEY     = 4'hF;
    addr    = 32'h0;
    isLoad  = 1'b0;
    isStore = 1'b0;
    wrData  = 32'h0;
    #12 reset = 1'b0;

    test_reset();
    test_latency();
    test_glitch();
    test_overrun();
    test_read_collision();
    test_intr();
    test_reset_held();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_key_io_device
